brick_game_ctrl: RTL

Game-level sequencer for the Bricks playfield. It owns the brick map and the paddle overlay, and drives the 192-bit occupancy map (12 rows × 16 cols, index = row*16+col) consumed by the ball mover. It paces the ball with a step-enable pulse, clears bricks the ball strikes, and tracks score, lives and game state (idle/serve/play/over/win).

---
 rtl/brick_game_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/brick_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : brick_game_ctrl
// Purpose  : Bricks game sequencer: brick map, paddle overlay, ball pacing,
//            brick clearing, score, lives and game state.
// Revision : 1.0 - initial release
// ============================================================================
module brick_game_ctrl #(
    parameter int TICK_DIV   = 25_000_000,
    parameter int LIVES      = 3,
    parameter int BRICK_ROWS = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   ball_row,
    input  logic [3:0]   ball_col,
    input  logic [1:0]   ball_dir,
    input  logic [3:0]   paddle_col,
    output logic [191:0] data,
    output logic         step,
    output logic         ball_reset_n,
    output logic [7:0]   score,
    output logic [2:0]   lives,
    output logic [2:0]   state
);
    localparam int                c_nbits    = 16 * BRICK_ROWS;
    localparam logic [25:0]       c_tick_max = 26'(TICK_DIV - 1);
    localparam logic [2:0]        c_lives    = 3'(LIVES);
    localparam logic signed [4:0] c_rows     = 5'(BRICK_ROWS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_OVER  = 3'd3,
        S_WIN   = 3'd4
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_start_q, r_ball_reset_n;
    logic [c_nbits-1:0] r_bricks;
    logic [25:0]        r_tick;
    logic [7:0]         r_score;
    logic [2:0]         r_lives;
    logic               w_start_edge, w_step, w_all_clear, w_miss, w_load, w_lose_life;
    logic signed [4:0]  w_row, w_col, w_vr, w_hc;
    logic [255:0]       w_map, w_clr;
    logic               w_v, w_h, w_d;
    logic [1:0]         w_hits;
    logic [8:0]         w_score_sum;
    logic [15:0]        w_paddle;

    // Column 15+1 overflows the 5-bit signed range to -16, so it fails the c >= 0 test.
    function automatic logic is_brick(input logic [255:0] map,
                                      input logic signed [4:0] r,
                                      input logic signed [4:0] c);
        if (r < 5'sd0 || r >= c_rows || c < 5'sd0)
            return 1'b0;
        return map[{r[3:0], c[3:0]}];
    endfunction

    assign w_start_edge = start & ~r_start_q;
    assign w_step       = (r_state == S_PLAY) && (r_tick == c_tick_max);
    assign w_all_clear  = (r_bricks == '0);
    assign w_miss       = (ball_row == 4'd11);
    assign w_map        = 256'(r_bricks);

    assign w_row = $signed({1'b0, ball_row});
    assign w_col = $signed({1'b0, ball_col});
    assign w_vr  = ball_dir[1] ? w_row + 5'sd1 : w_row - 5'sd1;
    assign w_hc  = ball_dir[0] ? w_col + 5'sd1 : w_col - 5'sd1;

    assign w_v = is_brick(w_map, w_vr, w_col);
    assign w_h = is_brick(w_map, w_row, w_hc);
    assign w_d = is_brick(w_map, w_vr, w_hc);

    // The diagonal brick only counts when the ball slips between two empty cells.
    always_comb begin
        w_clr = '0;
        if (w_v)
            w_clr[{w_vr[3:0], w_col[3:0]}] = 1'b1;
        if (w_h)
            w_clr[{w_row[3:0], w_hc[3:0]}] = 1'b1;
        if (w_d && !w_v && !w_h)
            w_clr[{w_vr[3:0], w_hc[3:0]}] = 1'b1;
    end

    assign w_hits      = 2'(w_v) + 2'(w_h) + 2'(w_d & ~w_v & ~w_h);
    assign w_score_sum = {1'b0, r_score} + {7'd0, w_hits};

    always_comb begin
        w_paddle = '0;
        for (int c = 0; c < 16; c++)
            w_paddle[c] = (5'(c) >= {1'b0, paddle_col}) && (5'(c) <= {1'b0, paddle_col} + 5'd2);
    end

    assign data = {w_paddle, 176'd0} | 192'(r_bricks);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_lose_life = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_state_nxt = S_SERVE;
                    w_load      = 1'b1;
                end
            end
            S_SERVE: begin
                if (w_start_edge)
                    w_state_nxt = S_PLAY;
            end
            S_PLAY: begin
                if (w_all_clear) begin
                    w_state_nxt = S_WIN;
                end else if (w_miss) begin
                    w_lose_life = 1'b1;
                    w_state_nxt = ((r_lives - 3'd1) == 3'd0) ? S_OVER : S_SERVE;
                end
            end
            S_OVER, S_WIN: begin
                if (w_start_edge)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_start_q      <= 1'b0;
            r_ball_reset_n <= 1'b1;
            r_tick         <= '0;
            r_bricks       <= '1;
            r_score        <= '0;
            r_lives        <= c_lives;
        end else begin
            r_start_q      <= start;
            r_ball_reset_n <= !((w_state_nxt == S_SERVE) && (r_state != S_SERVE));

            if ((r_state == S_PLAY) && (w_state_nxt == S_PLAY))
                r_tick <= w_step ? '0 : r_tick + 26'd1;
            else
                r_tick <= '0;

            if (w_load) begin
                r_bricks <= '1;
                r_score  <= '0;
                r_lives  <= c_lives;
            end else begin
                if (w_step) begin
                    r_bricks <= r_bricks & ~w_clr[c_nbits-1:0];
                    r_score  <= w_score_sum[8] ? 8'd255 : w_score_sum[7:0];
                end
                if (w_lose_life)
                    r_lives <= r_lives - 3'd1;
            end
        end
    end

    assign step         = w_step;
    assign ball_reset_n = r_ball_reset_n;
    assign score        = r_score;
    assign lives        = r_lives;
    assign state        = r_state;

endmodule
`default_nettype wire
